// File: rtl/pong_paddle_ctrl.sv
// Two-player Pong paddle controller.
// Each paddle has its own small speed FSM (IDLE/SLOW/MED/FAST) that advances
// once per video frame while a key is held. The position is a registered
// top-edge Y that saturates at the top and bottom walls.

module pong_paddle_ctrl #(
    parameter int unsigned SCREEN_H     = 480,
    parameter int unsigned PAD_H        = 64,
    parameter int unsigned Y_INIT       = 208,
    parameter int unsigned ACCEL_FRAMES = 8,
    parameter int unsigned V_SLOW       = 2,
    parameter int unsigned V_MED        = 4,
    parameter int unsigned V_FAST       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       uppad1,
    input  logic       downpad1,
    input  logic       uppad2,
    input  logic       downpad2,
    input  logic       pause,
    input  logic       recentre,
    output logic [9:0] pad1_y,
    output logic [9:0] pad2_y,
    output logic       pad1_moving,
    output logic       pad2_moving
);

    // Speed-level FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SLOW = 2'd1;
    localparam logic [1:0] ST_MED  = 2'd2;
    localparam logic [1:0] ST_FAST = 2'd3;

    // Last-direction encoding.
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_UP   = 2'd1;
    localparam logic [1:0] DIR_DOWN = 2'd2;

    localparam int unsigned HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;

    // A level lasts ACCEL_FRAMES moves. The counter holds the number of moves
    // already made at the current level, so the tick that enters SLOW (which
    // itself moves V_SLOW) leaves it at 1, while a level-up leaves it at 0
    // because that tick moved at the old speed.
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ACCEL_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ENTRY = (ACCEL_FRAMES > 1) ? HOLD_W'(1) : '0;

    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - PAD_H);
    localparam logic [9:0]  Y_RST     = 10'(Y_INIT);
    localparam logic [10:0] STEP_SLOW = 11'(V_SLOW);
    localparam logic [10:0] STEP_MED  = 11'(V_MED);
    localparam logic [10:0] STEP_FAST = 11'(V_FAST);

    logic       w_eval;
    logic [1:0] w_up_keys;
    logic [1:0] w_down_keys;
    logic [9:0] w_pad_y [2];
    logic [1:0] w_pad_moving;

    // recentre wins over a coincident tick, so it also blocks evaluation.
    assign w_eval      = frame_tick & ~pause & ~recentre;
    assign w_up_keys   = {uppad2, uppad1};
    assign w_down_keys = {downpad2, downpad1};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic [1:0]        w_dir;
        logic [1:0]        r_state;
        logic [1:0]        w_state_d;
        logic [1:0]        r_last_dir;
        logic [1:0]        w_last_dir_d;
        logic [HOLD_W-1:0] r_hold;
        logic [HOLD_W-1:0] w_hold_d;
        logic              w_move;
        logic [10:0]       w_step;
        logic [10:0]       w_y_ext;
        logic [10:0]       w_y_up;
        logic [10:0]       w_y_down;
        logic [9:0]        r_y;
        logic [9:0]        w_y_d;
        logic              r_moving;

        // Resolve held keys to one direction; opposing keys cancel out.
        always_comb begin
            unique case ({w_up_keys[g], w_down_keys[g]})
                2'b10:   w_dir = DIR_UP;
                2'b01:   w_dir = DIR_DOWN;
                default: w_dir = DIR_NONE;
            endcase
        end

        // Speed FSM next state; the step uses the level held before the tick.
        always_comb begin
            w_state_d    = r_state;
            w_hold_d     = r_hold;
            w_last_dir_d = r_last_dir;
            w_move       = 1'b0;
            w_step       = '0;
            if (w_eval) begin
                if (w_dir == DIR_NONE) begin
                    w_state_d = ST_IDLE;
                    w_hold_d  = '0;
                end else if ((r_state == ST_IDLE) || (w_dir != r_last_dir)) begin
                    w_state_d    = ST_SLOW;
                    w_hold_d     = HOLD_ENTRY;
                    w_last_dir_d = w_dir;
                    w_move       = 1'b1;
                    w_step       = STEP_SLOW;
                end else begin
                    w_move = 1'b1;
                    unique case (r_state)
                        ST_SLOW: begin
                            w_step = STEP_SLOW;
                            if (r_hold == HOLD_LAST) begin
                                w_state_d = ST_MED;
                                w_hold_d  = '0;
                            end else begin
                                w_hold_d = r_hold + 1'b1;
                            end
                        end
                        ST_MED: begin
                            w_step = STEP_MED;
                            if (r_hold == HOLD_LAST) begin
                                w_state_d = ST_FAST;
                                w_hold_d  = '0;
                            end else begin
                                w_hold_d = r_hold + 1'b1;
                            end
                        end
                        default: begin
                            // FAST is absorbing while the direction holds.
                            w_step = STEP_FAST;
                            w_hold_d = '0;
                        end
                    endcase
                end
            end
        end

        // Saturating position update in 11-bit arithmetic.
        always_comb begin
            w_y_ext  = {1'b0, r_y};
            w_y_up   = w_y_ext - w_step;
            w_y_down = w_y_ext + w_step;
            w_y_d    = r_y;
            if (w_move) begin
                if (w_dir == DIR_UP) begin
                    w_y_d = (w_y_ext < w_step) ? '0 : w_y_up[9:0];
                end else begin
                    w_y_d = (w_y_down > Y_MAX) ? Y_MAX[9:0] : w_y_down[9:0];
                end
            end
        end

        // State, position and registered moving flag.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state    <= ST_IDLE;
                r_hold     <= '0;
                r_last_dir <= DIR_NONE;
                r_y        <= Y_RST;
                r_moving   <= 1'b0;
            end else if (recentre) begin
                r_state    <= ST_IDLE;
                r_hold     <= '0;
                r_last_dir <= DIR_NONE;
                r_y        <= Y_RST;
                r_moving   <= 1'b0;
            end else begin
                r_state    <= w_state_d;
                r_hold     <= w_hold_d;
                r_last_dir <= w_last_dir_d;
                r_y        <= w_y_d;
                r_moving   <= (w_state_d != ST_IDLE);
            end
        end

        assign w_pad_y[g]      = r_y;
        assign w_pad_moving[g] = r_moving;
    end

    assign pad1_y      = w_pad_y[0];
    assign pad2_y      = w_pad_y[1];
    assign pad1_moving = w_pad_moving[0];
    assign pad2_moving = w_pad_moving[1];

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Bench for pong_paddle_ctrl: directed scenarios with literal expectations
// plus a long randomized run, all checked against a per-paddle model that
// tracks speed level and moves-made-at-level.

module tb_pong_paddle_ctrl;

    localparam int Y0   = 208;
    localparam int YMAX = 416;
    localparam int ACC  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       uppad1 = 1'b0;
    logic       downpad1 = 1'b0;
    logic       uppad2 = 1'b0;
    logic       downpad2 = 1'b0;
    logic       pause = 1'b0;
    logic       recentre = 1'b0;
    logic [9:0] pad1_y;
    logic [9:0] pad2_y;
    logic       pad1_moving;
    logic       pad2_moving;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: position, level (0 idle .. 3 fast), moves at level, last dir.
    int m_y   [2];
    int m_lvl [2];
    int m_cnt [2];
    int m_dir [2];

    int exp35 [20] = '{206, 204, 202, 200, 198, 196, 194, 192,
                       188, 184, 180, 176, 172, 168, 164, 160,
                       152, 144, 136, 128};

    pong_paddle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .uppad1      (uppad1),
        .downpad1    (downpad1),
        .uppad2      (uppad2),
        .downpad2    (downpad2),
        .pause       (pause),
        .recentre    (recentre),
        .pad1_y      (pad1_y),
        .pad2_y      (pad2_y),
        .pad1_moving (pad1_moving),
        .pad2_moving (pad2_moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int speed(input int lvl);
        if (lvl == 1) return 2;
        if (lvl == 2) return 4;
        return 8;
    endfunction

    function automatic int moved(input int y, input int dir, input int s);
        if (dir == 1) return (y < s) ? 0 : y - s;
        return (y + s > YMAX) ? YMAX : y + s;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_y[c]   = Y0;
            m_lvl[c] = 0;
            m_cnt[c] = 0;
            m_dir[c] = 0;
        end
    endtask

    task automatic model_step();
        logic u;
        logic d;
        int   dir;
        if (!rst_n) return;
        if (recentre) begin
            model_reset();
            return;
        end
        if (!frame_tick || pause) return;
        for (int c = 0; c < 2; c++) begin
            u   = (c == 0) ? uppad1 : uppad2;
            d   = (c == 0) ? downpad1 : downpad2;
            dir = (u && !d) ? 1 : ((!u && d) ? 2 : 0);
            if (dir == 0) begin
                m_lvl[c] = 0;
                m_cnt[c] = 0;
            end else if (m_lvl[c] == 0 || dir != m_dir[c]) begin
                m_y[c]   = moved(m_y[c], dir, 2);
                m_lvl[c] = 1;
                m_cnt[c] = 1;
                m_dir[c] = dir;
            end else begin
                m_y[c] = moved(m_y[c], dir, speed(m_lvl[c]));
                if (m_lvl[c] < 3) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == ACC) begin
                        m_lvl[c]++;
                        m_cnt[c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("pad1_y", int'(pad1_y), m_y[0]);
        chk("pad2_y", int'(pad2_y), m_y[1]);
        chk("pad1_moving", int'(pad1_moving), int'(m_lvl[0] != 0));
        chk("pad2_moving", int'(pad2_moving), int'(m_lvl[1] != 0));
    endtask

    // Called at a negedge: drive, let the edge happen, then check.
    task automatic cyc(input logic t, input logic u1, input logic d1, input logic u2,
                       input logic d2, input logic p, input logic r);
        frame_tick = t;
        uppad1     = u1;
        downpad1   = d1;
        uppad2     = u2;
        downpad2   = d2;
        pause      = p;
        recentre   = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // Asynchronous reset mid-cycle; released on the following negedge.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_pad1_y", int'(pad1_y), 208);
        chk("rst_pad2_y", int'(pad2_y), 208);
        chk("rst_pad1_moving", int'(pad1_moving), 0);
        chk("rst_pad2_moving", int'(pad2_moving), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic ku1;
        logic kd1;
        logic ku2;
        logic kd2;
        logic kp;
        ku1 = 1'b0;
        kd1 = 1'b0;
        ku2 = 1'b0;
        kd2 = 1'b0;
        kp  = 1'b0;

        model_reset();
        repeat (2) @(negedge clk);
        chk("init_pad1_y", int'(pad1_y), 208);
        chk("init_pad2_y", int'(pad2_y), 208);
        chk("init_pad1_moving", int'(pad1_moving), 0);
        chk("init_pad2_moving", int'(pad2_moving), 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0);

        // Acceleration profile with uppad1 held.
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 0, 0, 0, 0, 0);
            chk("accel_pad1_y", int'(pad1_y), exp35[i]);
            chk("accel_pad2_y", int'(pad2_y), 208);
        end
        // Reversal from FAST restarts at SLOW.
        cyc(1, 0, 1, 0, 0, 0, 0);
        chk("reverse_pad1_y", int'(pad1_y), 130);
        chk("reverse_moving", int'(pad1_moving), 1);

        // Both keys cancel.
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 1, 1, 0, 0, 0, 0);
            chk("both_pad1_y", int'(pad1_y), 208);
            chk("both_moving", int'(pad1_moving), 0);
        end
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("release_pad1_y", int'(pad1_y), 206);

        // Bottom wall saturation.
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) begin
            cyc(1, 0, 0, 0, 1, 0, 0);
            chk("bottom_moving", int'(pad2_moving), 1);
        end
        chk("bottom_pad2_y", int'(pad2_y), 416);

        // Top wall saturation.
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 60; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("top_pad1_y", int'(pad1_y), 0);
        chk("top_moving", int'(pad1_moving), 1);

        // Pause freezes position and speed level.
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        chk("prepause_pad1_y", int'(pad1_y), 184);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, 1, 1, 0);
            cyc(0, 1, 0, 0, 1, 1, 0);
        end
        chk("paused_pad1_y", int'(pad1_y), 184);
        chk("paused_pad2_y", int'(pad2_y), 208);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("unpause_pad1_y", int'(pad1_y), 180);

        // Reset mid-FAST, then recentre coincident with a tick.
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 17; i++) cyc(1, 0, 1, 0, 1, 0, 0);
        chk("fast_pad1_y", int'(pad1_y), 264);
        reset_pulse();
        cyc(1, 0, 1, 0, 1, 0, 1);
        chk("recentre_pad1_y", int'(pad1_y), 208);
        chk("recentre_pad2_y", int'(pad2_y), 208);
        chk("recentre_moving", int'(pad1_moving), 0);
        cyc(1, 0, 1, 0, 0, 0, 0);
        chk("after_recentre_pad1_y", int'(pad1_y), 210);

        // A tick on the first edge after reset release is processed.
        for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0, 0, 0);
        reset_pulse();
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("release_tick_pad1_y", int'(pad1_y), 206);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) ku1 = ~ku1;
            if ($urandom_range(39) == 0) kd1 = ~kd1;
            if ($urandom_range(39) == 0) ku2 = ~ku2;
            if ($urandom_range(39) == 0) kd2 = ~kd2;
            if ($urandom_range(99) == 0) kp = ~kp;
            if (i % 700 == 350) reset_pulse();
            cyc(($urandom_range(2) == 0), ku1, kd1, ku2, kd2, kp, ($urandom_range(199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
